range_stats_tracker: RTL and testbench
======================================

Name: range_stats_tracker

Overview:
- Parametrised successor to the single-shot range finder.
- Captures min and max over a go/finish-delimited window of qualified samples (data_valid strobe) and counts the samples.
- At finish it latches a mode-selected result (range, min, max or midpoint) with a valid flag.
- Reports protocol faults as an encoded, sticky error. Sits behind the chip's io_in/io_out pins as the measurement core.

Parameters:
- WIDTH, 16, sample and result width in bits.
- CNT_WIDTH, 8, sample counter width; the counter saturates.

Ports:
- clock  input  1  system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- data_in  input  WIDTH  unsigned sample.
- data_valid  input  1  sample qualifier; data_in is used only when this is 1.
- go  input  1  start or restart a measurement window.
- finish  input  1  close the window and latch the result.
- mode  input  2  result select: 00 range, 01 min, 10 max, 11 midpoint. Sampled on the finish cycle.
- result  output  WIDTH  latched result.
- result_valid  output  1  high while result holds a completed measurement.
- count  output  CNT_WIDTH  samples in the current or last window, saturating.
- busy  output  1  high in RUN.
- error  output  2  00 none, 01 go and finish together, 10 finish without go, 11 empty window. Sticky.

Behaviour:
- One clock domain. Reset is synchronous, active-high, checked on the rising edge of clock.
- Reset values: state IDLE; min and max 0; count 0; result 0; result_valid 0; busy 0; error 00.
- States: IDLE, RUN, DONE (all registered). busy = (state==RUN), decoded from the state register.
- Start condition: go=1 and finish=0 in any state.
  - Next state is RUN.
  - count, min and max are cleared; result_valid goes to 0; error goes to 00.
  - If data_valid=1 in the same cycle, that sample is the first sample: min=max=data_in, count=1.
  - In RUN this is a restart; all prior data is discarded.
- Sample update in RUN, when data_valid=1:
  - First sample (count==0) loads min and max.
  - Otherwise min<=data_in if data_in<min; max<=data_in if data_in>max. Comparisons are unsigned.
  - count increments and saturates at 2^CNT_WIDTH-1. min/max keep updating after saturation.
- Finish in RUN (finish=1, go=0):
  - A same-cycle valid sample is included before the result is computed.
  - If the effective count is 0: next state IDLE, error=11, result unchanged, result_valid stays 0.
  - Otherwise next state DONE; result and result_valid=1 are registered on that edge. result_valid is high the cycle after finish.
- Result arithmetic (uses effective min/max, including the same-cycle sample):
  - range = max-min, WIDTH bits, never negative.
  - midpoint = (min+max)>>1, computed at WIDTH+1 bits (no overflow), truncated toward zero.
- go and finish together, in any state:
  - error=01; next state IDLE; result_valid goes to 0; samples in that cycle are ignored.
  - result and count hold their values.
- finish=1, go=0 in IDLE or DONE: error=10; state, result and result_valid unchanged.
- DONE:
  - result, result_valid and count hold until a start condition or a go+finish fault.
  - data_valid is ignored.
- IDLE: data_valid is ignored.
- error is sticky: cleared only by reset or a start condition. A later fault overwrites it.
- Reset mid-RUN or mid-DONE returns all registers to their reset values on that edge; no partial result is emitted.

Test Plan:
- Basic range (WIDTH=10, mode=00): reset; go with data_valid and 100; samples 40, 700, 300; finish -> result=660, count=4, result_valid=1 on the cycle after finish, busy=0, error=00.
- Same-cycle edge samples and modes:
  - go with data 5 on the start cycle; finish with data_valid and 1023 on the same cycle, mode=11 -> result=514, count=2.
  - Repeat with mode=01 -> 5; mode=10 -> 1023.
- Errors:
  - finish in IDLE -> error=10, state stays IDLE.
  - go+finish in RUN -> error=01, result_valid=0, state IDLE.
  - go, then finish with no data_valid -> error=11.
  - A following clean go -> error=00.
- Restart and hold:
  - In RUN with min=10, max=900, pulse go with data 50 -> window restarts; then 60 and finish -> range=10, count=2.
  - After DONE, extra data_valid pulses leave result and count unchanged.
- Saturation (CNT_WIDTH=4): 20 valid samples -> count=15; min/max still track sample 20 (value 2000 % 1024 = 976 becomes max).
- Synchronous reset: assert reset mid-RUN -> next edge busy=0, count=0, result=0, error=00. Reset held low-to-high between edges has no effect until the next clock edge.

Source files
------------

// File: rtl/range_stats_tracker.sv
// range_stats_tracker
//   Measurement core: tracks min/max and a saturating sample count over a
//   go/finish-delimited window of qualified samples, then latches a
//   mode-selected result (range, min, max, midpoint) with a valid flag.
//   Protocol faults are reported as a sticky 2-bit error code.
//
// Ports
//   clock        system clock, all state on rising edge
//   reset        synchronous, active-high reset
//   data_in      unsigned sample, qualified by data_valid
//   data_valid   sample qualifier
//   go           start / restart a window
//   finish       close the window and latch the result
//   mode         result select: 00 range, 01 min, 10 max, 11 midpoint
//   result       latched result
//   result_valid high while result holds a completed measurement
//   count        samples in current/last window (saturating)
//   busy         high while a window is open
//   error        00 none, 01 go+finish, 10 finish without go, 11 empty window
module range_stats_tracker #(
  parameter int WIDTH     = 16,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     data_in,
  input  logic                 data_valid,
  input  logic                 go,
  input  logic                 finish,
  input  logic [1:0]           mode,
  output logic [WIDTH-1:0]     result,
  output logic                 result_valid,
  output logic [CNT_WIDTH-1:0] count,
  output logic                 busy,
  output logic [1:0]           error
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;
  localparam logic [1:0]           E_NONE    = 2'b00;
  localparam logic [1:0]           E_GOFIN   = 2'b01;
  localparam logic [1:0]           E_NOGO    = 2'b10;
  localparam logic [1:0]           E_EMPTY   = 2'b11;

  state_t               r_state;
  logic [WIDTH-1:0]     r_min, r_max, r_result;
  logic                 r_valid;
  logic [CNT_WIDTH-1:0] r_count;
  logic [1:0]           r_error;

  // Effective window statistics including this cycle's sample (if any).
  logic [WIDTH-1:0]     w_min, w_max, w_range, w_mid, w_sel;
  logic [CNT_WIDTH-1:0] w_cnt;

  always_comb begin
    w_min = r_min;
    w_max = r_max;
    w_cnt = r_count;
    if (data_valid) begin
      if (r_count == '0) begin
        w_min = data_in;
        w_max = data_in;
      end else begin
        if (data_in < r_min) w_min = data_in;
        if (data_in > r_max) w_max = data_in;
      end
      if (r_count != CNT_MAX) w_cnt = r_count + 1'b1;
    end
  end

  // max >= min always, so min + (max-min)/2 equals floor((min+max)/2)
  // without needing a WIDTH+1 bit adder.
  assign w_range = w_max - w_min;
  assign w_mid   = w_min + (w_range >> 1);

  always_comb begin
    w_sel = w_range;
    case (mode)
      2'b00: w_sel = w_range;
      2'b01: w_sel = w_min;
      2'b10: w_sel = w_max;
      2'b11: w_sel = w_mid;
      default: w_sel = w_range;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_min    <= '0;
      r_max    <= '0;
      r_count  <= '0;
      r_result <= '0;
      r_valid  <= 1'b0;
      r_error  <= E_NONE;
    end else if (go && finish) begin
      // fault: samples dropped, result and count held
      r_error <= E_GOFIN;
      r_state <= S_IDLE;
      r_valid <= 1'b0;
    end else if (go) begin
      r_state <= S_RUN;
      r_valid <= 1'b0;
      r_error <= E_NONE;
      if (data_valid) begin
        r_min   <= data_in;
        r_max   <= data_in;
        r_count <= {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      end else begin
        r_min   <= '0;
        r_max   <= '0;
        r_count <= '0;
      end
    end else if (finish) begin
      if (r_state == S_RUN) begin
        r_min   <= w_min;
        r_max   <= w_max;
        r_count <= w_cnt;
        if (w_cnt == '0) begin
          r_state <= S_IDLE;
          r_error <= E_EMPTY;
        end else begin
          r_state  <= S_DONE;
          r_result <= w_sel;
          r_valid  <= 1'b1;
        end
      end else begin
        r_error <= E_NOGO;
      end
    end else if (r_state == S_RUN) begin
      r_min   <= w_min;
      r_max   <= w_max;
      r_count <= w_cnt;
    end
  end

  assign result       = r_result;
  assign result_valid = r_valid;
  assign count        = r_count;
  assign busy         = (r_state == S_RUN);
  assign error        = r_error;

endmodule

// File: tb/tb_range_stats_tracker.sv
module tb_range_stats_tracker;
  localparam int W  = 10;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clock = 0;
  logic          reset, data_valid, go, finish;
  logic [W-1:0]  data_in;
  logic [1:0]    mode;
  logic [W-1:0]  result;
  logic          result_valid, busy;
  logic [CW-1:0] count;
  logic [1:0]    error;

  int n_cmp = 0;
  int n_err = 0;

  range_stats_tracker #(.WIDTH(W), .CNT_WIDTH(CW)) dut (
    .clock(clock), .reset(reset), .data_in(data_in), .data_valid(data_valid),
    .go(go), .finish(finish), .mode(mode), .result(result),
    .result_valid(result_valid), .count(count), .busy(busy), .error(error)
  );

  always #5 clock = ~clock;

  // Behavioural model: the window is simply the list of accepted samples.
  int m_q[$];
  int m_st;      // 0 idle, 1 run, 2 done
  int m_res, m_rv, m_err;
  bit chk_on = 0;

  function automatic int win_min();
    int v = m_q[0];
    foreach (m_q[i]) if (m_q[i] < v) v = m_q[i];
    return v;
  endfunction
  function automatic int win_max();
    int v = m_q[0];
    foreach (m_q[i]) if (m_q[i] > v) v = m_q[i];
    return v;
  endfunction
  function automatic int m_cnt();
    return (m_q.size() > CMAX) ? CMAX : m_q.size();
  endfunction

  always @(posedge clock) begin
    if (reset) begin
      m_q.delete(); m_st = 0; m_res = 0; m_rv = 0; m_err = 0;
    end else if (go && finish) begin
      m_err = 1; m_st = 0; m_rv = 0;
    end else if (go) begin
      m_q.delete();
      if (data_valid) m_q.push_back(int'(data_in));
      m_st = 1; m_rv = 0; m_err = 0;
    end else if (finish) begin
      if (m_st == 1) begin
        if (data_valid) m_q.push_back(int'(data_in));
        if (m_q.size() == 0) begin
          m_st = 0; m_err = 3;
        end else begin
          case (mode)
            2'd0: m_res = win_max() - win_min();
            2'd1: m_res = win_min();
            2'd2: m_res = win_max();
            default: m_res = (win_min() + win_max()) / 2;
          endcase
          m_rv = 1; m_st = 2;
        end
      end else begin
        m_err = 2;
      end
    end else if (m_st == 1 && data_valid) begin
      m_q.push_back(int'(data_in));
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model.
  always @(negedge clock) begin
    if (chk_on) begin
      chk("m_result", int'(result), m_res);
      chk("m_valid", int'(result_valid), m_rv);
      chk("m_count", int'(count), m_cnt());
      chk("m_busy", int'(busy), (m_st == 1) ? 1 : 0);
      chk("m_error", int'(error), m_err);
    end
  end

  task automatic cyc(input bit g, input bit f, input bit dv, input int d, input int md);
    go = g; finish = f; data_valid = dv; data_in = W'(d); mode = 2'(md);
    @(posedge clock); #1;
  endtask

  task automatic idle(); cyc(0, 0, 0, 0, 0); endtask

  initial begin
    reset = 1; go = 0; finish = 0; data_valid = 0; data_in = '0; mode = '0;
    @(posedge clock); #1;
    chk_on = 1;
    chk("rst_result", int'(result), 0);
    chk("rst_valid", int'(result_valid), 0);
    chk("rst_count", int'(count), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_error", int'(error), 0);
    reset = 0;
    idle();

    // basic range
    cyc(1, 0, 1, 100, 0);
    cyc(0, 0, 1, 40, 0);
    cyc(0, 0, 1, 700, 0);
    cyc(0, 0, 1, 300, 0);
    chk("basic_busy_run", int'(busy), 1);
    cyc(0, 1, 0, 0, 0);
    chk("basic_result", int'(result), 660);
    chk("basic_count", int'(count), 4);
    chk("basic_valid", int'(result_valid), 1);
    chk("basic_busy", int'(busy), 0);
    chk("basic_error", int'(error), 0);
    idle();

    // same-cycle edge samples, each mode
    cyc(1, 0, 1, 5, 0);   cyc(0, 1, 1, 1023, 3);
    chk("mid_result", int'(result), 514);
    chk("mid_count", int'(count), 2);
    cyc(1, 0, 1, 5, 0);   cyc(0, 1, 1, 1023, 1);
    chk("min_result", int'(result), 5);
    cyc(1, 0, 1, 5, 0);   cyc(0, 1, 1, 1023, 2);
    chk("max_result", int'(result), 1023);
    idle();

    // errors
    cyc(1, 0, 1, 33, 0);
    cyc(1, 1, 1, 44, 0);
    chk("gofin_error", int'(error), 1);
    chk("gofin_valid", int'(result_valid), 0);
    chk("gofin_busy", int'(busy), 0);
    chk("gofin_count", int'(count), 1);
    cyc(0, 1, 0, 0, 0);
    chk("nogo_error", int'(error), 2);
    chk("nogo_busy", int'(busy), 0);
    cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    chk("empty_error", int'(error), 3);
    chk("empty_count", int'(count), 0);
    chk("empty_valid", int'(result_valid), 0);
    cyc(1, 0, 0, 0, 0);
    chk("clean_go_error", int'(error), 0);
    chk("clean_go_busy", int'(busy), 1);

    // restart discards prior data
    cyc(0, 0, 1, 10, 0);
    cyc(0, 0, 1, 900, 0);
    cyc(1, 0, 1, 50, 0);
    cyc(0, 1, 1, 60, 0);
    chk("restart_result", int'(result), 10);
    chk("restart_count", int'(count), 2);
    // DONE ignores samples
    cyc(0, 0, 1, 1000, 0);
    cyc(0, 0, 1, 1, 0);
    cyc(0, 0, 1, 500, 0);
    chk("hold_result", int'(result), 10);
    chk("hold_count", int'(count), 2);
    chk("hold_valid", int'(result_valid), 1);

    // saturation: 20 samples, the last is the max
    cyc(1, 0, 1, 10, 0);
    for (int i = 2; i <= 19; i++) cyc(0, 0, 1, i * 10, 0);
    cyc(0, 0, 1, 976, 0);
    chk("sat_count", int'(count), 15);
    cyc(0, 1, 0, 0, 2);
    chk("sat_max", int'(result), 976);
    cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    cyc(1, 0, 1, 3, 0);
    for (int i = 0; i < 18; i++) cyc(0, 0, 1, 400, 0);
    cyc(0, 1, 0, 0, 1);
    chk("sat_min", int'(result), 3);
    chk("sat_count2", int'(count), 15);

    // synchronous reset mid-RUN
    cyc(1, 0, 1, 7, 0);
    cyc(0, 0, 1, 8, 0);
    reset = 1; go = 0; data_valid = 0;
    #2;
    chk("rst_async_busy", int'(busy), 1);
    chk("rst_async_count", int'(count), 2);
    @(posedge clock); #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_count", int'(count), 0);
    chk("rst_result", int'(result), 0);
    chk("rst_error", int'(error), 0);
    reset = 0;
    idle(); idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
